// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-op encodings, data width and the
// memory-access FSM state type.
package cpu_pkg;

    localparam int DATA_W = 32;

    // EX/MEM memory-op field encodings (2'b11 is treated as no access)
    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_WR   = 2'b01;
    localparam logic [1:0] MEM_RD   = 2'b10;

    // Memory-access FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    // True for the two encodings that touch data memory
    function automatic logic is_access(input logic [1:0] op);
        return (op == MEM_WR) || (op == MEM_RD);
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB output register. A load captures a full write-back slot;
// otherwise the slot empties (valid/wb/err drop) while the destination
// and data fields hold their last values.
module memwb_reg
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic              i_wb,
    input  logic [4:0]        i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_err,
    output logic              o_valid,
    output logic              o_wb,
    output logic [4:0]        o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_err
);

    logic              r_valid;
    logic              r_wb;
    logic [4:0]        r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;

    // Capture a write-back slot on load, otherwise bubble; err is a pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_wb      <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else if (i_load) begin
            r_valid   <= i_valid;
            r_wb      <= i_wb;
            r_rd_addr <= i_rd_addr;
            r_rd_data <= i_rd_data;
            r_err     <= i_err;
        end else begin
            r_valid   <= 1'b0;
            r_wb      <= 1'b0;
            r_err     <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_wb      = r_wb;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;
    assign o_err     = r_err;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, abandons
// an access after TIMEOUT_CYC unacknowledged WAIT cycles, and feeds the
// MEM/WB register.
//
// Handshake: dmem_req_o rises the cycle after an access is accepted and
// stays high, with we/addr/wdata constant, until the first cycle in
// which dmem_ack_i is high (or the timeout fires); dmem_rdata_i is
// sampled only in that ack cycle. Ack while no request is open is ignored.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose
// address is not word aligned (no request, one-cycle err_o, wb squashed).
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              wb_i,
    input  logic [1:0]        mem_i,
    input  logic [DATA_W-1:0] memaddr_i,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [DATA_W-1:0] alures_i,
    input  logic [4:0]        rd_addr_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              valid_o,
    output logic              wb_o,
    output logic [4:0]        rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              err_o
);

    // Counter value seen in the last permitted WAIT cycle (counter is 0 in the first)
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_lat_wb;
    logic              r_lat_load;
    logic [4:0]        r_lat_rd;
    logic [DATA_W-1:0] r_lat_alu;

    logic              w_access;
    logic              w_bad_align;
    logic              w_issue;
    logic              w_timeout;

    logic              w_wb_load;
    logic              w_wb_wb;
    logic              w_wb_err;
    logic [4:0]        w_wb_rd;
    logic [DATA_W-1:0] w_wb_data;

    assign w_access = valid_i && is_access(mem_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_bad_align = w_access && (memaddr_i[1:0] != 2'b00);
`else
    assign w_bad_align = 1'b0;
`endif

    assign w_issue   = w_access && !w_bad_align;
    assign w_timeout = (r_state == ST_WAIT) && !dmem_ack_i && (r_cnt == LP_CNT_LAST);

    // Stall while accepting an access or while it is still outstanding; never in reset
    assign stall_o = rst_i &&
                     (((r_state == ST_IDLE) && w_issue) ||
                      ((r_state == ST_WAIT) && !dmem_ack_i && !w_timeout));

    // Select what, if anything, the MEM/WB register captures this cycle
    always_comb begin
        w_wb_load = 1'b0;
        w_wb_wb   = 1'b0;
        w_wb_err  = 1'b0;
        w_wb_rd   = rd_addr_i;
        w_wb_data = alures_i;
        case (r_state)
            ST_IDLE: begin
                if (valid_i && !w_issue) begin
                    w_wb_load = 1'b1;
                    w_wb_wb   = w_bad_align ? 1'b0 : wb_i;
                    w_wb_err  = w_bad_align;
                end
            end
            ST_WAIT: begin
                w_wb_rd   = r_lat_rd;
                w_wb_data = r_lat_alu;
                if (dmem_ack_i) begin
                    w_wb_load = 1'b1;
                    w_wb_wb   = r_lat_wb;
                    if (r_lat_load) begin
                        w_wb_data = dmem_rdata_i;
                    end
                end else if (w_timeout) begin
                    w_wb_load = 1'b1;
                    w_wb_err  = 1'b1;
                end
            end
            default: begin
                w_wb_load = 1'b0;
            end
        endcase
    end

    // FSM, timeout counter and registered memory request
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat_wb   <= 1'b0;
            r_lat_load <= 1'b0;
            r_lat_rd   <= '0;
            r_lat_alu  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state    <= ST_WAIT;
                        r_cnt      <= '0;
                        r_req      <= 1'b1;
                        r_we       <= mem_i[0];
                        r_addr     <= memaddr_i;
                        r_wdata    <= memdata_i;
                        r_lat_wb   <= wb_i;
                        r_lat_load <= mem_i[1];
                        r_lat_rd   <= rd_addr_i;
                        r_lat_alu  <= alures_i;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack_i || w_timeout) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;

    memwb_reg u_memwb_reg (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_load    (w_wb_load),
        .i_valid   (1'b1),
        .i_wb      (w_wb_wb),
        .i_rd_addr (w_wb_rd),
        .i_rd_data (w_wb_data),
        .i_err     (w_wb_err),
        .o_valid   (valid_o),
        .o_wb      (wb_o),
        .o_rd_addr (rd_addr_o),
        .o_rd_data (rd_data_o),
        .o_err     (err_o)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (TIMEOUT_CYC = 4). A memory
// responder acks after a programmable number of request cycles; expected
// write-back slots come from a transaction-level model kept in exp_q.
// Build with MEM_ALIGN_CHECK_EN to also exercise the alignment check.
module tb_mem_access_stage;

    localparam int TO = 4;
    localparam int W  = 40;  // {check_data, err, wb, rd[4:0], data[31:0]}

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        wb_i = 1'b0;
    logic [1:0]  mem_i = 2'b00;
    logic [31:0] memaddr_i = '0;
    logic [31:0] memdata_i = '0;
    logic [31:0] alures_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        valid_o;
    logic        wb_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  ref_mem[logic [31:0]];
    logic [31:0]  resp_mem[logic [31:0]];

    // responder control
    int          ack_lat = 0;
    bit          no_ack = 1'b0;
    bit          force_ack = 1'b0;
    int          req_cycles = 0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .wb_i         (wb_i),
        .mem_i        (mem_i),
        .memaddr_i    (memaddr_i),
        .memdata_i    (memdata_i),
        .alures_i     (alures_i),
        .rd_addr_i    (rd_addr_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .valid_o      (valid_o),
        .wb_o         (wb_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .err_o        (err_o)
    );

    // Contents of a never-written word
    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dmem_ack_i   = force_ack;
            dmem_rdata_i = $urandom;
            if (dmem_req_o === 1'b1) begin
                if (!no_ack && req_cycles == ack_lat) begin
                    dmem_ack_i = 1'b1;
                    n_cmp++;
                    if (dmem_we_o !== cur_we || dmem_addr_o !== cur_addr) begin
                        n_bad++;
                        $display("FAIL dmem_cmd: got we=%0b addr=%h, want we=%0b addr=%h",
                                 dmem_we_o, dmem_addr_o, cur_we, cur_addr);
                    end
                    if (dmem_we_o === 1'b1) begin
                        n_cmp++;
                        if (dmem_wdata_o !== cur_wdata) begin
                            n_bad++;
                            $display("FAIL dmem_wdata: got %h, want %h", dmem_wdata_o, cur_wdata);
                        end
                        resp_mem[dmem_addr_o] = dmem_wdata_o;
                    end else begin
                        dmem_rdata_i = resp_mem.exists(dmem_addr_o) ? resp_mem[dmem_addr_o]
                                                                    : mem_default(dmem_addr_o);
                    end
                end
                req_cycles++;
            end else begin
                req_cycles = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wb_unexpected: got valid_o=1 rd=%0d data=%h, want no slot",
                             rd_addr_o, rd_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({err_o, wb_o, rd_addr_o} !== e[38:32] ||
                        (e[39] && rd_data_o !== e[31:0])) begin
                        n_bad++;
                        $display("FAIL wb_slot: got err=%0b wb=%0b rd=%0d data=%h, want err=%0b wb=%0b rd=%0d data=%h",
                                 err_o, wb_o, rd_addr_o, rd_data_o, e[38], e[37], e[36:32], e[31:0]);
                    end
                end
            end
            if (err_o === 1'b1) begin
                n_cmp++;
                if (valid_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL err_without_valid: got valid_o=%0b, want 1", valid_o);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // kind: 0 ALU(00), 1 ALU(11), 2 store, 3 load. Starts 2 time units after an edge.
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] alu, input logic [4:0] rd, input logic wb,
                         input int lat);
        logic [31:0] d;
        int stalls;
        int exp_stalls;
        valid_i   = 1'b1;
        mem_i     = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b11 : (kind == 2) ? 2'b01 : 2'b10;
        memaddr_i = addr;
        memdata_i = wdata;
        alures_i  = alu;
        rd_addr_i = rd;
        wb_i      = wb;
        cur_we    = (kind == 2);
        cur_addr  = addr;
        cur_wdata = wdata;
        ack_lat   = lat;
        d = alu;
        if (kind == 2) ref_mem[addr] = wdata;
        if (kind == 3) d = ref_read(addr);
        exp_stalls = (kind >= 2) ? lat + 1 : 0;
        exp_q.push_back({1'b1, 1'b0, wb, rd, d});
        #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 50) begin
            stalls++;
            @(posedge clk);
            #3;
        end
        n_cmp++;
        if (stalls != exp_stalls) begin
            n_bad++;
            $display("FAIL stall_cycles: got %0d, want %0d (kind %0d)", stalls, exp_stalls, kind);
        end
        @(posedge clk);
        #2;
        valid_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL complete: got valid_o=%0b req=%0b, want valid_o=1 req=0", valid_o, dmem_req_o);
        end
    endtask

    task automatic idle_cycle();
        valid_i = 1'b0;
        mem_i   = 2'($urandom_range(0, 3));
        @(posedge clk);
        #2;
        n_cmp++;
        if (valid_o !== 1'b0 || wb_o !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_bubble: got valid_o=%0b wb_o=%0b, want 0 0", valid_o, wb_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, valid_o, wb_o, rd_addr_o,
             rd_data_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL %s: got req=%0b we=%0b addr=%h wdata=%h valid=%0b wb=%0b rd=%0d data=%h err=%0b, want all 0",
                     name, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, valid_o, wb_o,
                     rd_addr_o, rd_data_o, err_o);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b0; valid_i = 1'b1; mem_i = 2'b10; memaddr_i = 32'h40;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset_outputs");
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %0b, want 0", stall_o);
        end
        rst_i = 1'b1; valid_i = 1'b0;
        idle_cycle();
    endtask

    task automatic test_alu_op();
        issue(0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0);
        issue(1, 32'h8, 32'h0, 32'hCAFE_0001, 5'd31, 1'b0, 0);
        idle_cycle();
    endtask

    task automatic test_load_latency();
        ref_mem[32'h100]  = 32'hDEADBEEF;
        resp_mem[32'h100] = 32'hDEADBEEF;
        issue(3, 32'h100, 32'h0, 32'h77, 5'd7, 1'b1, 3);
        issue(3, 32'h104, 32'h0, 32'h78, 5'd8, 1'b1, 0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        ack_lat = 0;
        valid_i = 1'b1; mem_i = 2'b01; memaddr_i = 32'h200; memdata_i = 32'hA5A5_1234;
        alures_i = 32'h11; rd_addr_i = 5'd3; wb_i = 1'b1;
        cur_we = 1'b1; cur_addr = 32'h200; cur_wdata = 32'hA5A5_1234;
        ref_mem[32'h200] = 32'hA5A5_1234;
        exp_q.push_back({1'b1, 1'b0, 1'b1, 5'd3, 32'h11});
        @(posedge clk); #2;
        n_cmp++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_wdata_o !== 32'hA5A5_1234) begin
            n_bad++;
            $display("FAIL b2b_store_req: got req=%0b we=%0b wdata=%h, want 1 1 a5a51234",
                     dmem_req_o, dmem_we_o, dmem_wdata_o);
        end
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ack_stall: got %0b, want 0", stall_o);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (dmem_req_o !== 1'b0 || valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_gap: got req=%0b valid=%0b, want 0 1", dmem_req_o, valid_o);
        end
        mem_i = 2'b10; rd_addr_i = 5'd4; alures_i = 32'h22;
        cur_we = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 1'b1, 5'd4, ref_read(32'h200)});
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept_stall: got %0b, want 1", stall_o);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_load_req: got req=%0b we=%0b, want 1 0", dmem_req_o, dmem_we_o);
        end
        @(posedge clk); #2;
        valid_i = 1'b0;
        n_cmp++;
        if (dmem_req_o !== 1'b0 || valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_load_done: got req=%0b valid=%0b, want 0 1", dmem_req_o, valid_o);
        end
        idle_cycle();
    endtask

    task automatic test_timeout();
        no_ack = 1'b1;
        valid_i = 1'b1; mem_i = 2'b10; memaddr_i = 32'h300; rd_addr_i = 5'd9; wb_i = 1'b1;
        alures_i = 32'h99;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 5'd9, 32'h0});
        @(posedge clk); #2;
        valid_i = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            n_cmp++;
            if (dmem_req_o !== 1'b1) begin
                n_bad++;
                $display("FAIL timeout_req: cycle %0d got req=%0b, want 1", i, dmem_req_o);
            end
            #1;
            n_cmp++;
            if (stall_o !== (i < TO)) begin
                n_bad++;
                $display("FAIL timeout_stall: cycle %0d got %0b, want %0b", i, stall_o, (i < TO));
            end
            @(posedge clk); #2;
        end
        n_cmp++;
        if (dmem_req_o !== 1'b0 || err_o !== 1'b1 || valid_o !== 1'b1 || wb_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_end: got req=%0b err=%0b valid=%0b wb=%0b, want 0 1 1 0",
                     dmem_req_o, err_o, valid_o, wb_o);
        end
        force_ack = 1'b1;
        @(posedge clk); #2;
        force_ack = 1'b0;
        @(posedge clk); #2;
        n_cmp++;
        if (valid_o !== 1'b0 || dmem_req_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ack: got valid=%0b req=%0b err=%0b, want 0 0 0", valid_o, dmem_req_o, err_o);
        end
        no_ack = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        no_ack = 1'b1;
        valid_i = 1'b1; mem_i = 2'b01; memaddr_i = 32'h400; memdata_i = 32'h5555_AAAA;
        rd_addr_i = 5'd12; wb_i = 1'b1; alures_i = 32'h1;
        @(posedge clk); #2;
        force_ack = 1'b1;
        @(posedge clk); #2;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_wait_reset_stall: got %0b, want 0", stall_o);
        end
        @(posedge clk); #2;
        force_ack = 1'b0; rst_i = 1'b1; valid_i = 1'b0; no_ack = 1'b0;
        check_all_zero("mid_wait_reset");
        issue(0, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd13, 1'b1, 0);
        idle_cycle();
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        valid_i = 1'b1; mem_i = 2'b10; memaddr_i = 32'h102; rd_addr_i = 5'd6; wb_i = 1'b1;
        alures_i = 32'h66;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 5'd6, 32'h0});
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL align_stall: got %0b, want 0", stall_o);
        end
        @(posedge clk); #2;
        valid_i = 1'b0;
        n_cmp++;
        if (dmem_req_o !== 1'b0 || err_o !== 1'b1 || valid_o !== 1'b1 || wb_o !== 1'b0) begin
            n_bad++;
            $display("FAIL align_err: got req=%0b err=%0b valid=%0b wb=%0b, want 0 1 1 0",
                     dmem_req_o, err_o, valid_o, wb_o);
        end
        idle_cycle();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 4);
            a = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
            if (k == 4) idle_cycle();
            else issue(k, a, $urandom, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), $urandom_range(0, TO - 1));
        end
    endtask

    task automatic test_drain();
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending slots, want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu_op();
        test_load_latency();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
